// File: rtl/fpu_f2i_unpack_if.sv
// Handshake and data bundle between the float-to-int unpack FIFO and its neighbours.
// The master drives operands, flush and out-ready; the slave is the FIFO.
interface fpu_f2i_unpack_if #(
  parameter int C_OP   = 32,
  parameter int C_EXP  = 8,
  parameter int C_MANT = 23,
  parameter int C_TAG  = 4
);
  logic              In_valid_SI;
  logic              In_ready_SO;
  logic [C_OP-1:0]   Operand_a_DI;
  logic [C_TAG-1:0]  Tag_DI;
  logic              Flush_SI;
  logic              Out_valid_SO;
  logic              Out_ready_SI;
  logic              Sign_a_DO;
  logic [C_EXP-1:0]  Exp_a_DO;
  logic [C_MANT:0]   Mant_a_DO;
  logic [C_TAG-1:0]  Tag_DO;
  logic              Is_zero_SO;
  logic              Is_denorm_SO;
  logic              Is_inf_SO;
  logic              Is_nan_SO;
  logic              Is_snan_SO;
  logic [1:0]        Count_DO;

  modport master (
    output In_valid_SI, Operand_a_DI, Tag_DI,
    output Flush_SI, Out_ready_SI,
    input  In_ready_SO, Out_valid_SO,
    input  Sign_a_DO, Exp_a_DO, Mant_a_DO, Tag_DO,
    input  Is_zero_SO, Is_denorm_SO, Is_inf_SO,
    input  Is_nan_SO, Is_snan_SO, Count_DO
  );

  modport slave (
    input  In_valid_SI, Operand_a_DI, Tag_DI,
    input  Flush_SI, Out_ready_SI,
    output In_ready_SO, Out_valid_SO,
    output Sign_a_DO, Exp_a_DO, Mant_a_DO, Tag_DO,
    output Is_zero_SO, Is_denorm_SO, Is_inf_SO,
    output Is_nan_SO, Is_snan_SO, Count_DO
  );
endinterface

// File: rtl/fpu_f2i_unpack.sv
// 2-entry FIFO of unpacked single-precision operands for the float-to-int stage.
// Ports: Clk_CI, Rst_RBI (async low), io (slave: operand/tag in, unpacked head out).
module fpu_f2i_unpack #(
  parameter int C_OP   = 32,
  parameter int C_EXP  = 8,
  parameter int C_MANT = 23,
  parameter int C_TAG  = 4
) (
  input  logic           Clk_CI,
  input  logic           Rst_RBI,
  fpu_f2i_unpack_if.slave io
);

  typedef struct packed {
    logic              sign;
    logic [C_EXP-1:0]  exp;
    logic [C_MANT:0]   mant;
    logic [C_TAG-1:0]  tag;
    logic              zero;
    logic              denorm;
    logic              inf;
    logic              nan;
    logic              snan;
  } ent_t;

  ent_t             mem [2];
  ent_t             ent;
  ent_t             head;
  logic [1:0]       count;
  logic             wptr;
  logic             rptr;
  logic             push;
  logic             pop;
  logic [C_EXP-1:0] e;
  logic [C_MANT-1:0] f;
  logic             e_zero;
  logic             e_max;
  logic             f_zero;

  assign e      = io.Operand_a_DI[C_OP-2 -: C_EXP];
  assign f      = io.Operand_a_DI[C_MANT-1:0];
  assign e_zero = (e == '0);
  assign e_max  = &e;
  assign f_zero = (f == '0);

  always_comb begin
    ent        = '0;
    ent.sign   = io.Operand_a_DI[C_OP-1];
    ent.exp    = e;
    ent.mant   = {1'b1, f};
    ent.tag    = io.Tag_DI;
    unique case (1'b1)
      e_zero & f_zero: begin
        ent.mant = '0;
        ent.zero = 1'b1;
      end
      e_zero & ~f_zero: begin
        // denormals are flushed to a signed zero
        ent.mant   = '0;
        ent.zero   = 1'b1;
        ent.denorm = 1'b1;
      end
      e_max & f_zero: begin
        ent.mant = '0;
        ent.inf  = 1'b1;
      end
      e_max & ~f_zero: begin
        ent.mant = {1'b0, f};
        ent.nan  = 1'b1;
        ent.snan = ~f[C_MANT-1];
      end
      default: ;
    endcase
  end

  assign io.In_ready_SO  = (count != 2'd2);
  assign io.Out_valid_SO = (count != 2'd0);

  assign push = io.In_valid_SI & io.In_ready_SO & ~io.Flush_SI;
  assign pop  = io.Out_valid_SO & io.Out_ready_SI & ~io.Flush_SI;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else if (io.Flush_SI) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (push) mem[wptr] <= ent;
  end

  // storage is hidden while empty, so reset zeroes outputs at once
  assign head = io.Out_valid_SO ? mem[rptr] : '0;

  assign io.Sign_a_DO    = head.sign;
  assign io.Exp_a_DO     = head.exp;
  assign io.Mant_a_DO    = head.mant;
  assign io.Tag_DO       = head.tag;
  assign io.Is_zero_SO   = head.zero;
  assign io.Is_denorm_SO = head.denorm;
  assign io.Is_inf_SO    = head.inf;
  assign io.Is_nan_SO    = head.nan;
  assign io.Is_snan_SO   = head.snan;
  assign io.Count_DO     = count;

endmodule
